// File: rtl/terminal_writer.sv
// Byte-stream terminal writer: decodes printables and CR/LF/BS/TAB into
// character-RAM writes at a tracked cursor, with deferred wrap and scroll requests.
module terminal_writer #(
  parameter int unsigned COLS      = 100,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned TAB_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_low,
  output logic                      character_ready,
  input  logic                      character_valid,
  input  logic [7:0]                character_byte,
  input  logic                      write_ready,
  output logic                      write_valid,
  output logic [$clog2(ROWS)-1:0]   write_row,
  output logic [$clog2(COLS)-1:0]   write_col,
  output logic [7:0]                write_byte,
  input  logic                      scroll_ready,
  output logic                      scroll_valid,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [$clog2(COLS)-1:0]   cursor_col
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t        state;
  logic          wrap_pending;
  logic          scroll_then_write;
  logic [31:0]   tab_sum_c;
  logic [CW-1:0] tab_col_c;
  logic          printable_c;

  // Next tab stop, computed wide so it cannot overflow before clamping to the last column.
  always_comb begin
    tab_sum_c   = (32'(cursor_col) | 32'(TAB_WIDTH - 1)) + 32'd1;
    tab_col_c   = (tab_sum_c > 32'(LAST_COL)) ? LAST_COL : CW'(tab_sum_c);
    printable_c = (character_byte >= 8'h20) && (character_byte <= 8'h7E);
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state             <= IDLE;
      character_ready   <= 1'b1;
      write_valid       <= 1'b0;
      write_row         <= '0;
      write_col         <= '0;
      write_byte        <= '0;
      scroll_valid      <= 1'b0;
      cursor_row        <= '0;
      cursor_col        <= '0;
      wrap_pending      <= 1'b0;
      scroll_then_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (character_valid) begin
            if (printable_c) begin
              character_ready <= 1'b0;
              write_byte      <= character_byte;
              if (!wrap_pending) begin
                write_row   <= cursor_row;
                write_col   <= cursor_col;
                write_valid <= 1'b1;
                state       <= WRITE;
              end else begin
                // Deferred wrap: the character lands at column 0 of the next line.
                wrap_pending <= 1'b0;
                cursor_col   <= '0;
                write_col    <= '0;
                if (cursor_row < LAST_ROW) begin
                  cursor_row  <= cursor_row + RW'(1);
                  write_row   <= cursor_row + RW'(1);
                  write_valid <= 1'b1;
                  state       <= WRITE;
                end else begin
                  write_row         <= LAST_ROW;
                  scroll_valid      <= 1'b1;
                  scroll_then_write <= 1'b1;
                  state             <= SCROLL;
                end
              end
            end else begin
              case (character_byte)
                CH_CR: begin
                  cursor_col   <= '0;
                  wrap_pending <= 1'b0;
                end
                CH_LF: begin
                  wrap_pending <= 1'b0;
                  if (cursor_row < LAST_ROW) begin
                    cursor_row <= cursor_row + RW'(1);
                  end else begin
                    character_ready   <= 1'b0;
                    scroll_valid      <= 1'b1;
                    scroll_then_write <= 1'b0;
                    state             <= SCROLL;
                  end
                end
                CH_BS: begin
                  wrap_pending <= 1'b0;
                  if (cursor_col != '0) cursor_col <= cursor_col - CW'(1);
                end
                CH_TAB: begin
                  wrap_pending <= 1'b0;
                  cursor_col   <= tab_col_c;
                end
                default: ;
              endcase
            end
          end
        end
        SCROLL: begin
          if (scroll_ready) begin
            scroll_valid <= 1'b0;
            if (scroll_then_write) begin
              write_valid <= 1'b1;
              state       <= WRITE;
            end else begin
              character_ready <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        WRITE: begin
          if (write_ready) begin
            write_valid     <= 1'b0;
            character_ready <= 1'b1;
            state           <= IDLE;
            if (cursor_col < LAST_COL) cursor_col   <= cursor_col + CW'(1);
            else                       wrap_pending <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          character_ready <= 1'b1;
          write_valid     <= 1'b0;
          scroll_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_terminal_writer.sv
// Directed bench for terminal_writer with default geometry (100 x 30, tab 8).
module tb_terminal_writer;

  logic       clk = 1'b0;
  logic       reset_low;
  logic       character_ready;
  logic       character_valid;
  logic [7:0] character_byte;
  logic       write_ready;
  logic       write_valid;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_byte;
  logic       scroll_ready;
  logic       scroll_valid;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  int errors = 0;
  int checks = 0;

  terminal_writer #(.COLS(100), .ROWS(30), .TAB_WIDTH(8)) dut (
    .clk             (clk),
    .reset_low       (reset_low),
    .character_ready (character_ready),
    .character_valid (character_valid),
    .character_byte  (character_byte),
    .write_ready     (write_ready),
    .write_valid     (write_valid),
    .write_row       (write_row),
    .write_col       (write_col),
    .write_byte      (write_byte),
    .scroll_ready    (scroll_ready),
    .scroll_valid    (scroll_valid),
    .cursor_row      (cursor_row),
    .cursor_col      (cursor_col)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset_low       = 1'b0;
    character_valid = 1'b0;
    character_byte  = 8'h00;
    write_ready     = 1'b1;
    scroll_ready    = 1'b0;
    repeat (2) @(negedge clk);
    reset_low = 1'b1;
  endtask

  // Offer one byte at a negedge once ready; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!character_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!character_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: character_ready=%0b required 1", character_ready);
    end
    character_valid = 1'b1;
    character_byte  = b;
    @(negedge clk);
    character_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_low = 1'b0;
    character_valid = 1'b0;
    write_ready = 1'b0;
    scroll_ready = 1'b0;
    #12;
    checks++;
    if ({write_valid, scroll_valid, character_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_flags: wv/sv/cr=%b required 001", {write_valid, scroll_valid, character_ready});
    end
    checks++;
    if ({write_row, write_col, write_byte, cursor_row, cursor_col} !== '0) begin
      errors++;
      $display("FAIL reset_regs: row=%0d col=%0d byte=%h cur=%0d,%0d required all 0",
               write_row, write_col, write_byte, cursor_row, cursor_col);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    send(8'h41);
    checks++;
    if ({write_valid, write_row, write_col, write_byte} !== {1'b1, 5'd0, 7'd0, 8'h41}) begin
      errors++;
      $display("FAIL single_write: v=%0b row=%0d col=%0d byte=%h required 1,0,0,41",
               write_valid, write_row, write_col, write_byte);
    end
    @(negedge clk);
    checks++;
    if ({write_valid, cursor_row, cursor_col, character_ready} !== {1'b0, 5'd0, 7'd1, 1'b1}) begin
      errors++;
      $display("FAIL single_after: v=%0b cur=%0d,%0d rdy=%0b required 0,0,1,1",
               write_valid, cursor_row, cursor_col, character_ready);
    end
  endtask

  task automatic test_stall();
    do_reset();
    write_ready = 1'b0;
    send(8'h42);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({write_valid, write_row, write_col, write_byte, character_ready} !==
          {1'b1, 5'd0, 7'd0, 8'h42, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: v=%0b row=%0d col=%0d byte=%h rdy=%0b required 1,0,0,42,0",
                 i, write_valid, write_row, write_col, write_byte, character_ready);
      end
      @(negedge clk);
    end
    write_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({write_valid, cursor_col, character_ready} !== {1'b0, 7'd1, 1'b1}) begin
      errors++;
      $display("FAIL stall_release: v=%0b col=%0d rdy=%0b required 0,1,1",
               write_valid, cursor_col, character_ready);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send(8'h30 + 8'(i % 10));
      checks++;
      if (write_valid !== 1'b1 || write_col !== 7'(i) || write_row !== 5'd0) begin
        errors++;
        $display("FAIL wrap_write[%0d]: v=%0b row=%0d col=%0d required 1,0,%0d",
                 i, write_valid, write_row, write_col, i);
      end
    end
    @(negedge clk);
    checks++;
    if ({cursor_row, cursor_col} !== {5'd0, 7'd99}) begin
      errors++;
      $display("FAIL wrap_last_cursor: cur=%0d,%0d required 0,99", cursor_row, cursor_col);
    end
    send(8'h5A);
    checks++;
    if ({write_valid, write_row, write_col, write_byte} !== {1'b1, 5'd1, 7'd0, 8'h5A}) begin
      errors++;
      $display("FAIL wrap_101: v=%0b row=%0d col=%0d byte=%h required 1,1,0,5a",
               write_valid, write_row, write_col, write_byte);
    end
    @(negedge clk);
    checks++;
    if ({cursor_row, cursor_col} !== {5'd1, 7'd1}) begin
      errors++;
      $display("FAIL wrap_101_cursor: cur=%0d,%0d required 1,1", cursor_row, cursor_col);
    end
  endtask

  task automatic test_scroll();
    do_reset();
    for (int i = 0; i < 29; i++) send(8'h0A);
    checks++;
    if (cursor_row !== 5'd29 || character_ready !== 1'b1) begin
      errors++;
      $display("FAIL lf_rows: row=%0d rdy=%0b required 29,1", cursor_row, character_ready);
    end
    send(8'h0A);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({scroll_valid, character_ready} !== 2'b10) begin
        errors++;
        $display("FAIL scroll_hold[%0d]: sv=%0b rdy=%0b required 1,0", i, scroll_valid, character_ready);
      end
      @(negedge clk);
    end
    scroll_ready = 1'b1;
    @(negedge clk);
    scroll_ready = 1'b0;
    checks++;
    if ({scroll_valid, character_ready, cursor_row, write_valid} !== {1'b0, 1'b1, 5'd29, 1'b0}) begin
      errors++;
      $display("FAIL scroll_done: sv=%0b rdy=%0b row=%0d wv=%0b required 0,1,29,0",
               scroll_valid, character_ready, cursor_row, write_valid);
    end
    // Fill the bottom row, then the deferred wrap must scroll before writing.
    for (int i = 0; i < 100; i++) send(8'h2E);
    @(negedge clk);
    scroll_ready = 1'b1;
    send(8'h51);
    checks++;
    if ({scroll_valid, write_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bottom_wrap_scroll: sv=%0b wv=%0b required 1,0", scroll_valid, write_valid);
    end
    @(negedge clk);
    scroll_ready = 1'b0;
    checks++;
    if ({write_valid, write_row, write_col, write_byte} !== {1'b1, 5'd29, 7'd0, 8'h51}) begin
      errors++;
      $display("FAIL bottom_wrap_write: v=%0b row=%0d col=%0d byte=%h required 1,29,0,51",
               write_valid, write_row, write_col, write_byte);
    end
    @(negedge clk);
  endtask

  task automatic test_controls();
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h20);
    @(negedge clk);
    checks++;
    if ({cursor_row, cursor_col} !== {5'd3, 7'd5}) begin
      errors++;
      $display("FAIL ctl_start: cur=%0d,%0d required 3,5", cursor_row, cursor_col);
    end
    send(8'h09);
    checks++;
    if (cursor_col !== 7'd8) begin
      errors++; $display("FAIL ctl_tab: col=%0d required 8", cursor_col);
    end
    send(8'h08);
    checks++;
    if (cursor_col !== 7'd7) begin
      errors++; $display("FAIL ctl_bs: col=%0d required 7", cursor_col);
    end
    send(8'h0D);
    checks++;
    if ({cursor_row, cursor_col} !== {5'd3, 7'd0}) begin
      errors++; $display("FAIL ctl_cr: cur=%0d,%0d required 3,0", cursor_row, cursor_col);
    end
    send(8'h07);
    checks++;
    if ({cursor_row, cursor_col, write_valid, character_ready} !== {5'd3, 7'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ctl_ignore: cur=%0d,%0d wv=%0b rdy=%0b required 3,0,0,1",
               cursor_row, cursor_col, write_valid, character_ready);
    end
    send(8'h08);
    checks++;
    if (cursor_col !== 7'd0) begin
      errors++; $display("FAIL ctl_bs_zero: col=%0d required 0", cursor_col);
    end
    for (int i = 0; i < 13; i++) send(8'h09);
    checks++;
    if (cursor_col !== 7'd99) begin
      errors++; $display("FAIL ctl_tab_clamp: col=%0d required 99", cursor_col);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h0A);
    write_ready = 1'b0;
    send(8'h43);
    #2;
    reset_low = 1'b0;
    #1;
    checks++;
    if ({write_valid, cursor_row, cursor_col, character_ready} !== {1'b0, 5'd0, 7'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: wv=%0b cur=%0d,%0d rdy=%0b required 0,0,0,1",
               write_valid, cursor_row, cursor_col, character_ready);
    end
    @(negedge clk);
    reset_low = 1'b1;
    write_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (write_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after: wv=%0b required 0", write_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stall();
    test_wrap();
    test_scroll();
    test_controls();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
